// File: rtl/adder_pkg.sv
// Shared types and constants for the multi-byte serial adder.
package adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        IDLE,
        ACTIVE
    } fsm_e;

    // One output beat as held by the output register.
    typedef struct packed {
        logic [BYTE_W-1:0] sum;
        logic              last;
        logic              cout;
        logic              ovf;
        logic              err;
    } out_beat_t;

endpackage

// File: rtl/cla_adder_8.sv
// 8-bit carry-lookahead adder: two 4-bit lookahead groups, with the high
// group's carry-in produced from the low group's generate/propagate.
module cla_adder_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       gg_lo;
    logic       pg_lo;

    // Generate/propagate, lookahead carries and sum.
    always_comb begin
        g = a & b;
        p = a ^ b;
        c = '0;

        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

        gg_lo = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pg_lo = &p[3:0];
        c[4]  = gg_lo | (pg_lo & cin);

        c[5] = g[4] | (p[4] & c[4]);
        c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
        c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4]) | (p[6] & p[5] & p[4] & c[4]);
        c[8] = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5]) | (p[7] & p[6] & p[5] & g[4])
             | (p[7] & p[6] & p[5] & p[4] & c[4]);

        sum  = p ^ c[7:0];
        cout = c[8];
    end

endmodule

// File: rtl/serial_out_reg.sv
// Valid/ready output register holding {sum, last, cout, ovf, err}.
// The ovf bit is only stored when MULTIBYTE_SERIAL_ADDER_OVF_EN is defined;
// otherwise it reads as 0.
import adder_pkg::*;

module serial_out_reg (
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  logic      out_ready,
    input  out_beat_t d,
    output logic      out_valid,
    output out_beat_t q
);

    logic              valid_q;
    logic [BYTE_W-1:0] sum_q;
    logic              last_q;
    logic              cout_q;
    logic              err_q;
    logic              ovf_q;

    // Valid flag: a load wins over a drain so back-to-back beats stay valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Payload: only changes on load, so it holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            last_q <= 1'b0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (load) begin
            sum_q  <= d.sum;
            last_q <= d.last;
            cout_q <= d.cout;
            err_q  <= d.err;
        end
    end

`ifdef MULTIBYTE_SERIAL_ADDER_OVF_EN
    // Overflow flag register, present only with the feature enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (load) begin
            ovf_q <= d.ovf;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = d.ovf;
    assign ovf_q      = 1'b0;
`endif

    // Repack the held fields.
    always_comb begin
        q.sum  = sum_q;
        q.last = last_q;
        q.cout = cout_q;
        q.ovf  = ovf_q;
        q.err  = err_q;
    end

    assign out_valid = valid_q;

endmodule

// File: rtl/multibyte_serial_adder.sv
// Streaming multi-byte adder: LS byte first, carry chained across beats,
// one sum byte out per accepted beat through a valid/ready register.
// Optional feature macro: MULTIBYTE_SERIAL_ADDER_OVF_EN (signed overflow flag).
import adder_pkg::*;

module multibyte_serial_adder #(
    parameter int N_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_a,
    input  logic [BYTE_W-1:0] in_b,
    input  logic              in_cin,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_cout,
    output logic              out_ovf,
    output logic              out_err
);

    localparam int CNT_W = $clog2(N_BYTES + 1);

    fsm_e              state_q, state_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic              treat_first;
    logic              add_cin;
    logic [BYTE_W-1:0] add_sum;
    logic              add_cout;
    logic              overrun;
    out_beat_t         beat;
    out_beat_t         held;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    cla_adder_8 u_adder (
        .a    (in_a),
        .b    (in_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Framing decisions, next-state and the beat to be registered.
    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        // In IDLE every beat starts a frame, flagged or not.
        treat_first = in_first || (state_q == IDLE);
        add_cin     = treat_first ? in_cin : carry_q;

        cnt_d   = treat_first ? CNT_W'(1) : cnt_q + CNT_W'(1);
        overrun = (cnt_d == CNT_W'(N_BYTES)) && !in_last;

        beat.sum  = add_sum;
        beat.last = in_last || overrun;
        beat.cout = beat.last && add_cout;
        beat.err  = ((state_q == IDLE) && !in_first) || ((state_q == ACTIVE) && in_first)
                  || overrun;
`ifdef MULTIBYTE_SERIAL_ADDER_OVF_EN
        // Carry into the MSB recovered from the sum bit; overflow = c7 ^ c8.
        beat.ovf  = beat.last && ((add_sum[7] ^ in_a[7] ^ in_b[7]) ^ add_cout);
`else
        beat.ovf  = 1'b0;
`endif

        if (accept) begin
            carry_d = add_cout;
            state_d = beat.last ? IDLE : ACTIVE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // FSM, carry chain and byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    serial_out_reg u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .out_ready (out_ready),
        .d         (beat),
        .out_valid (out_valid),
        .q         (held)
    );

    assign out_sum  = held.sum;
    assign out_last = held.last;
    assign out_cout = held.cout;
    assign out_ovf  = held.ovf;
    assign out_err  = held.err;

endmodule

// File: doc/multibyte_serial_adder.md
# multibyte_serial_adder

Streaming multi-byte adder that accepts two operands one byte per beat, least-significant byte first, and adds them using the team's 8-bit carry-lookahead adder as the per-beat arithmetic core. The carry is chained across beats in a register. Each sum byte is emitted through a registered valid/ready output stage, with the final carry and a signed-overflow flag reported on the last byte. The block sits directly upstream of the 8-bit adder: it sequences and feeds the adder, and consumes and registers what the adder produces. This extends byte-wide addition to operands of up to `N_BYTES` bytes.

## Interface
- `N_BYTES`, default 4 — maximum frame length in bytes; must be ≥ 2.
- `clk`  in  1  — single clock; everything is on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `in_valid`  in  1  — input beat valid.
- `in_ready`  out  1  — block accepts a beat this cycle.
- `in_a`  in  8  — operand A byte.
- `in_b`  in  8  — operand B byte.
- `in_cin`  in  1  — carry-in for the frame; sampled only on the first beat.
- `in_first`  in  1  — beat is the LS byte of a new frame.
- `in_last`  in  1  — beat is the MS byte of the frame.
- `out_valid`  out  1  — output beat valid.
- `out_ready`  in  1  — downstream accepts the output beat.
- `out_sum`  out  8  — sum byte.
- `out_last`  out  1  — output beat is the final byte of the frame.
- `out_cout`  out  1  — frame carry-out; meaningful only when `out_last`=1, otherwise 0.
- `out_ovf`  out  1  — signed overflow of the frame; meaningful only when `out_last`=1.
- `out_err`  out  1  — a framing error occurred on this beat.

## Operation
- **Accept.** A beat is accepted when `in_valid` and `in_ready` are both high.
- **Ready rule.** `in_ready = !out_valid || out_ready`, so the block sustains one beat per cycle.
- **FSM states.**
  - `IDLE` waits for the first beat of a frame.
  - `ACTIVE` means a frame is in progress.
- **Per-beat carry-in.** The adder carry-in is `in_cin` if the beat is first, else `carry_q`.
- **Registered on accept:**
  - `out_sum` ← adder sum.
  - `carry_q` ← adder cout.
  - `cnt` ← 1 on a first beat, else `cnt`+1.
  - The byte counter is `$clog2(N_BYTES+1)` bits wide.
- **IDLE transitions:**
  - A beat with `in_first`=1 starts a frame.
  - A beat with `in_first`=1 and `in_last`=1 is a 1-byte frame; the FSM stays in `IDLE`.
  - A beat with `in_first`=0 is still accepted and treated as first, with carry-in = `in_cin`; `out_err`=1 on that beat.
- **ACTIVE transitions:**
  - A beat with `in_last`=1 ends the frame → `IDLE`.
  - A beat with `in_first`=1 aborts the old frame and restarts: `cnt`=1, carry-in = `in_cin`, `out_err`=1, FSM stays in `ACTIVE` (or goes to `IDLE` if `in_last`=1).
- **Length overrun.** If an accepted beat makes `cnt` = `N_BYTES` without `in_last`:
  - The beat is forced to `out_last`=1 with `out_err`=1.
  - The FSM returns to `IDLE`.
  - The next beat is treated as in IDLE, and therefore also errors unless it has `in_first`=1.
- **On the last output byte:** `out_cout` = the registered carry and `out_ovf` = `carry_into_msb ^ cout` of that byte.
- **Unsigned arithmetic.** The frame result is mod 2^(8·len), with carry in `out_cout`.
- **Output hold.** While `out_valid && !out_ready`, all `out_*` signals hold stable and no beat is accepted.

## Timing
- **Latency.** 1 cycle: a beat accepted at edge k appears on `out_*` after edge k, with `out_valid`=1.
- **out_valid update.**
  - Set on accept.
  - Cleared on `out_ready` when no new accept occurs that cycle.
  - Simultaneous drain and accept keeps `out_valid`=1 and loads the new data.
- **Reset values.** Asynchronous reset drives, immediately:
  - `out_valid`=0, `out_sum`=0, `out_last`=0, `out_cout`=0, `out_ovf`=0, `out_err`=0.
  - `carry_q`=0, `cnt`=0, FSM=`IDLE`.
  - Consequently `in_ready`=1.
- **Reset mid-frame.** The partial frame is dropped, with no output for it.

## Configuration
- **Macro:** `MULTIBYTE_SERIAL_ADDER_OVF_EN`.
- **Defined:**
  - The carry into bit 7 is taken as `sum[7]^a[7]^b[7]`.
  - It is registered alongside the output, and `out_ovf` is computed as described in Operation.
- **Undefined:** `out_ovf` is tied to 0 and the ovf register and logic are not present. The port remains.

## Structure
- **Package `adder_pkg`** holds:
  - the FSM enum `fsm_e` {`IDLE`, `ACTIVE`};
  - the localparam `BYTE_W`=8.
- **Sub-modules:**
  - The existing 8-bit carry-lookahead adder is instantiated once as the arithmetic core.
  - One new sub-module, `serial_out_reg`, implements the valid/ready output register holding {sum, last, cout, ovf, err}.

## Test plan
- **3-byte frame, no errors.** A=0x0000FF, B=0x000001, `in_cin`=0, 3-byte frame, `out_ready`=1 → `out_sum` = 0x00, 0x01, 0x00; `out_last` on byte 3; `out_cout`=0; `out_err`=0.
- **Carry-out on last byte.** 2-byte frame, A=0xFFFF, B=0x0001 → sums 0x00, 0x00; `out_cout`=1; with the macro defined, `out_ovf`=0.
- **Signed overflow.** 1-byte frame, A=0x7F, B=0x01 → `out_sum`=0x80, `out_ovf`=1 with the macro defined, `out_ovf`=0 without.
- **Backpressure.** `out_ready`=0 for 3 cycles mid-frame → `in_ready`=0 and outputs stable throughout; no beat lost; the sum sequence is unchanged.
- **Overrun and restart.** With `N_BYTES`=4, send 4 beats without `in_last` → beat 4 has `out_last`=1 and `out_err`=1. Then `in_first` mid-frame → `out_err`=1 and the carry restarts from `in_cin`.
- **Reset mid-frame.** Assert `rst` during byte 2 of a frame → outputs go to 0 immediately; a subsequent fresh frame produces correct sums.
